// File: rtl/dac_arb_ctrl.sv
// Two-channel arbiter driving a parallel DAC write interface.
// Optional scope trigger on ch0 writes: define DAC_ARB_TRIG_EN.
module dac_arb_ctrl #(
    parameter int DW        = 10,
    parameter int SETUP_CYC = 2,
    parameter int WR_CYC    = 2,
    parameter int RST_CYC   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] ch0_data,
    input  logic          ch0_valid,
    output logic          ch0_ready,
    input  logic [DW-1:0] ch1_data,
    input  logic          ch1_valid,
    output logic          ch1_ready,
    output logic          pin_da_wr,
    output logic          pin_da_reset,
    output logic          pin_da_sel,
    output logic          pin_da_clk,
    output logic [DW-1:0] pin_da_dataout,
    output logic          fpga_ext_trig,
    output logic          busy
);

    localparam int MX01 = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
    localparam int MX   = (MX01 > RST_CYC) ? MX01 : RST_CYC;
    localparam int CW   = $clog2(MX + 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SETUP,
        WRITE,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ptr;
    logic          g0;
    logic          g1;
    logic          take0;
    logic          take1;

    // ptr=0 favours ch0 when both channels are requesting
    always_comb begin
        g0    = ch0_valid & (~ch1_valid | ~ptr);
        g1    = ch1_valid & (~ch0_valid | ptr);
        take0 = ch0_valid & ch0_ready;
        take1 = ch1_valid & ch1_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RST_HOLD;
            cnt            <= CW'(RST_CYC - 1);
            ptr            <= 1'b0;
            ch0_ready      <= 1'b0;
            ch1_ready      <= 1'b0;
            pin_da_reset   <= 1'b1;
            pin_da_wr      <= 1'b1;
            pin_da_sel     <= 1'b0;
            pin_da_clk     <= 1'b0;
            pin_da_dataout <= '0;
            busy           <= 1'b1;
        end else begin
            unique case (state)
                RST_HOLD: begin
                    if (cnt == '0) begin
                        state        <= IDLE;
                        pin_da_reset <= 1'b0;
                        busy         <= 1'b0;
                        ch0_ready    <= g0;
                        ch1_ready    <= g1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (take0 || take1) begin
                        state          <= SETUP;
                        cnt            <= CW'(SETUP_CYC - 1);
                        pin_da_dataout <= take0 ? ch0_data : ch1_data;
                        pin_da_sel     <= ~take0;
                        ptr            <= take0;
                        ch0_ready      <= 1'b0;
                        ch1_ready      <= 1'b0;
                        busy           <= 1'b1;
                    end else begin
                        ch0_ready <= g0;
                        ch1_ready <= g1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state     <= WRITE;
                        cnt       <= CW'(WR_CYC - 1);
                        pin_da_wr <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt == '0) begin
                        state      <= HOLD;
                        pin_da_wr  <= 1'b1;
                        pin_da_clk <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    state      <= IDLE;
                    pin_da_clk <= 1'b0;
                    busy       <= 1'b0;
                    ch0_ready  <= g0;
                    ch1_ready  <= g1;
                end
                default: begin
                    state <= RST_HOLD;
                    cnt   <= CW'(RST_CYC - 1);
                end
            endcase
        end
    end

`ifdef DAC_ARB_TRIG_EN
    logic trig;

    // fires on the edge that enters WRITE, so it spans the first strobe cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig <= 1'b0;
        end else begin
            trig <= (state == SETUP) && (cnt == '0) && !pin_da_sel;
        end
    end

    assign fpga_ext_trig = trig;
`else
    assign fpga_ext_trig = 1'b0;
`endif

endmodule

// File: doc/dac_arb_ctrl.md
DAC_ARB_CTRL -- requirements
Module: dac_arb_ctrl

Interface
REQ-001 SHALL have parameter DW, default 10, the DAC data width.
REQ-002 SHALL have parameter SETUP_CYC, default 2, the data/select setup cycles before the write strobe (legal >=1).
REQ-003 SHALL have parameter WR_CYC, default 2, the active-low write strobe width in cycles (legal >=1).
REQ-004 SHALL have parameter RST_CYC, default 16, the DAC reset hold cycles after reset release (legal >=1).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports ch0_data / ch1_data, input, DW: requester samples (ch0 = 2ASK output, ch1 = reference carrier).
REQ-008 SHALL have ports ch0_valid / ch1_valid, input, 1: sample offered.
REQ-009 SHALL have ports ch0_ready / ch1_ready, output, 1: sample accepted when valid and ready are both high.
REQ-010 SHALL have ports pin_da_wr (output, 1, active-low write), pin_da_reset (output, 1, active-high DAC reset), pin_da_sel (output, 1, channel select), pin_da_clk (output, 1, DAC latch clock), and pin_da_dataout (output, DW, DAC data).
REQ-011 SHALL have ports fpga_ext_trig (output, 1, scope trigger) and busy (output, 1, not IDLE).

Function
REQ-012 SHALL use FSM states RST_HOLD, IDLE, SETUP, WRITE, HOLD; all outputs are registered.
REQ-013 RST_HOLD: pin_da_reset=1 and both ready=0 for RST_CYC cycles, then IDLE.
REQ-014 IDLE: ready SHALL be high only for the granted channel; the grant goes to the only valid channel, or by round-robin if both are valid; the priority pointer starts at ch0 and moves to the other channel after each accepted transfer.
REQ-015 On transfer: latch the data into pin_da_dataout and the channel index into pin_da_sel on the next edge, then go to SETUP; ready SHALL deassert in every state except IDLE.
REQ-016 SETUP: hold for SETUP_CYC cycles with pin_da_wr=1; data and select stay stable.
REQ-017 WRITE: hold pin_da_wr=0 for WR_CYC cycles.
REQ-018 HOLD: one cycle with pin_da_wr=1 and pin_da_clk=1, then IDLE; pin_da_clk SHALL be 0 in every other state.
REQ-019 Data and select SHALL remain stable from latch until the next transfer.
REQ-020 Throughput SHALL be one sample per SETUP_CYC+WR_CYC+2 cycles (6 at defaults); valid held high with no transfer SHALL be kept waiting, never dropped.
REQ-021 A valid that deasserts in IDLE before a transfer SHALL cause no write.
REQ-022 busy SHALL be 0 only in IDLE.

Reset
REQ-023 rst_n low SHALL immediately force: state=RST_HOLD, pin_da_reset=1, pin_da_wr=1, pin_da_sel=0, pin_da_clk=0, pin_da_dataout=0, ready=0, fpga_ext_trig=0, busy=1, pointer=ch0.
REQ-024 Reset mid-write SHALL abort the write with no partial strobe after release; RST_HOLD SHALL restart its full RST_CYC count.

Configuration
REQ-025 With macro DAC_ARB_TRIG_EN defined, fpga_ext_trig SHALL pulse high for exactly one cycle, coincident with the first WRITE cycle of every ch0 write.
REQ-026 Without DAC_ARB_TRIG_EN, fpga_ext_trig SHALL be constant 0 and no trigger logic SHALL be synthesized.

Verification
REQ-027 Reset release at defaults -> pin_da_reset=1 for 16 cycles, then 0; no ready is asserted before then.
REQ-028 ch0 alone offers 0x2A5 -> ch0_ready for 1 cycle; pin_da_dataout=0x2A5, sel=0; wr=1 for 2 cycles, then 0 for 2 cycles, then 1; pin_da_clk=1 in the HOLD cycle.
REQ-029 Both channels continuously valid (ch0=0x100, ch1=0x3FF) -> writes alternate ch0, ch1, ch0, ...; sel toggles; a new write starts every 6 cycles.
REQ-030 rst_n pulsed low during the WRITE state -> pin_da_wr=1 in the same cycle; all outputs at their reset values; the 16-cycle hold restarts.
REQ-031 With DAC_ARB_TRIG_EN and alternating traffic -> one fpga_ext_trig pulse per ch0 write and none for ch1 writes; without the macro, fpga_ext_trig stays 0.
REQ-032 ch1_valid raised for 1 cycle while busy -> no ch1 write occurs, and ch1_ready stays 0.
